arb4_grant_lock: RTL and testbench
==================================

# arb4_grant_lock

Registered grant-holding stage directly downstream of the 4-way fixed-priority request arbitration. It samples four request lines, selects a winner by fixed priority (r[0] highest, r[3] lowest), and latches the grant until the owner drops its request. It drives a stable one-hot grant, an owner index and a busy flag to the shared-resource mux. An optional hold limit forces release so that a high-priority client cannot hold the resource indefinitely.

## Interface
- MAX_HOLD, 16, maximum consecutive GRANT cycles per ownership (≥1); used only when the hold limit is compiled in
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- r  input  [0:3]  request lines; r[0] highest priority
- g  output  [0:3]  registered one-hot grant; 4'b0000 when idle
- owner  output  [1:0]  index of granted client (0 = r[0]); 0 when idle
- busy  output  1  high while in GRANT
- timeout  output  1  one-cycle pulse when a grant is force-released; constant 0 when the hold limit is compiled out

## Operation
- Two states: IDLE and GRANT. All outputs are registered.
- Reset values: state IDLE, g=4'b0000, owner=0, busy=0, timeout=0, hold counter=0, skip mask=4'b0000.
- IDLE with r==0: stay in IDLE; outputs stay at their reset values.
- IDLE with r!=0: the winner is the lowest-index set bit of the effective requests.
  - Effective requests = r & ~mask when that is non-zero; otherwise r.
  - Next state is GRANT. g = one-hot of the winner, owner = winner index, busy=1, counter=1, mask cleared.
- GRANT: g and owner are frozen. Requests from other clients, including higher-priority ones, are ignored (no preemption).
- GRANT with r[owner]=0 sampled: next state IDLE, g=0, busy=0, owner=0.
- Hold limit (compiled in only): GRANT with r[owner]=1 and counter==MAX_HOLD:
  - next state IDLE, g=0, timeout=1 for one cycle;
  - mask = one-hot of the old owner, so that client loses the next arbitration if any other client requests.
- Otherwise in GRANT: counter increments and saturates at MAX_HOLD.
- Counter width: $clog2(MAX_HOLD+1).

## Timing
- Grant latency: a request sampled at edge n in IDLE gives g valid after edge n.
- Release latency: r[owner] low sampled at edge n gives g=0 after edge n.
- At least one IDLE cycle (g=0) always separates two grants. This is a guaranteed dead cycle for mux switchover.
- Simultaneous release and new requests: the release wins. Arbitration happens in the following IDLE cycle.
- Owner drops its request while a higher-priority request rises in the same cycle: release first, then the higher-priority client wins in IDLE.
- Requests at the cycle where counter reaches MAX_HOLD: the forced release takes effect on that edge, regardless of other requests.
- Reset asserted mid-GRANT: on the next edge all state and outputs return to reset values. There is no pulse on timeout.
- g is always one-hot or zero; it never changes within a GRANT.

## Configuration
- ARB_HOLD_LIMIT_EN defined:
  - hold counter, skip mask and timeout logic are present;
  - a forced release happens after MAX_HOLD grant cycles.
- ARB_HOLD_LIMIT_EN undefined:
  - there is no counter or mask, and MAX_HOLD is ignored;
  - a grant lasts until the owner deasserts;
  - timeout is tied to 0;
  - effective requests = r.

## Test plan
- Reset then single request: r=4'b0010 held 3 cycles then 0 → g=0010, owner=2, busy=1 for 3 cycles, then g=0000 the cycle after release.
- Priority: r=4'b0111 from IDLE → g=0100, owner=1. Then r=4'b1111 while owner still requests → g stays 0100 (no preemption).
- Handover: owner 1 drops while r=4'b1011 → one cycle g=0000, then g=1000, owner=0.
- Reset mid-grant: g=0001 and reset pulsed for one cycle → next edge g=0000, busy=0, owner=0, timeout=0. Requests held high are re-granted one cycle after reset deasserts.
- Hold limit (ARB_HOLD_LIMIT_EN, MAX_HOLD=4), r=4'b1100 held:
  - g=1000 for 4 cycles, then g=0000 with timeout=1;
  - then g=0100 (client 0 masked);
  - after client 1's limit, g=1000 again.
- Hold limit with a lone requester (ARB_HOLD_LIMIT_EN, MAX_HOLD=4), r=4'b0001 held → repeated 4-cycle grants of 0001 separated by single g=0000/timeout=1 cycles. Without the macro, g=0001 continuously and timeout=0.

Source files
------------

// File: rtl/arb4_grant_lock.sv
// Registered 4-way fixed-priority grant-holding stage (r[0] highest, no preemption).
// Optional hold limit with forced release and skip mask: define ARB_HOLD_LIMIT_EN.
module arb4_grant_lock #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [0:3] r,
    output logic [0:3] g,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout
);

    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("arb4_grant_lock: MAX_HOLD must be >= 1");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_nxt;
    logic [0:3] g_nxt;
    logic [1:0] owner_nxt;
    logic       busy_nxt;
    logic       timeout_nxt;
    logic [0:3] eff;
    logic [1:0] win;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] cnt, cnt_nxt;
    logic [0:3]    mask, mask_nxt;
`endif

    // The client that was force-released is skipped only if someone else is asking.
    always_comb begin
`ifdef ARB_HOLD_LIMIT_EN
        eff = ((r & ~mask) != 4'b0000) ? (r & ~mask) : r;
`else
        eff = r;
`endif
        win = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (eff[i]) win = 2'(i);
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_nxt   = state;
        g_nxt       = g;
        owner_nxt   = owner;
        busy_nxt    = busy;
        timeout_nxt = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
        cnt_nxt     = cnt;
        mask_nxt    = mask;
`endif
        case (state)
            IDLE: begin
                if (r != 4'b0000) begin
                    state_nxt  = GRANT;
                    g_nxt      = 4'b0000;
                    g_nxt[win] = 1'b1;
                    owner_nxt  = win;
                    busy_nxt   = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
                    cnt_nxt    = CW'(1);
                    mask_nxt   = 4'b0000;
`endif
                end
            end
            GRANT: begin
                if (!r[owner]) begin
                    state_nxt = IDLE;
                    g_nxt     = 4'b0000;
                    owner_nxt = 2'd0;
                    busy_nxt  = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
                    cnt_nxt   = '0;
                end else if (cnt == CW'(MAX_HOLD)) begin
                    state_nxt       = IDLE;
                    g_nxt           = 4'b0000;
                    owner_nxt       = 2'd0;
                    busy_nxt        = 1'b0;
                    timeout_nxt     = 1'b1;
                    cnt_nxt         = '0;
                    mask_nxt        = 4'b0000;
                    mask_nxt[owner] = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state   <= IDLE;
            g       <= 4'b0000;
            owner   <= 2'd0;
            busy    <= 1'b0;
            timeout <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            cnt     <= '0;
            mask    <= 4'b0000;
`endif
        end else begin
            state   <= state_nxt;
            g       <= g_nxt;
            owner   <= owner_nxt;
            busy    <= busy_nxt;
            timeout <= timeout_nxt;
`ifdef ARB_HOLD_LIMIT_EN
            cnt     <= cnt_nxt;
            mask    <= mask_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_arb4_grant_lock.sv
// Self-checking bench for arb4_grant_lock: directed scenarios plus random requests/resets,
// compared each cycle against an ownership-level reference model (honours ARB_HOLD_LIMIT_EN).
module tb_arb4_grant_lock;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:3] r;
    logic [0:3] g;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: who owns the resource, for how long, and who is skipped next.
    int m_owner = -1;
    int m_held  = 0;
    int m_skip  = -1;
    bit m_to    = 1'b0;

    arb4_grant_lock #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .reset   (reset),
        .r       (r),
        .g       (g),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [0:3] rv, input logic rs);
        int w;
        m_to = 1'b0;
        if (rs) begin
            m_owner = -1;
            m_held  = 0;
            m_skip  = -1;
        end else if (m_owner < 0) begin
            if (rv != 4'b0000) begin
                w = -1;
                for (int i = 0; i < 4; i++)
                    if (w < 0 && rv[i] && i != m_skip) w = i;
                if (w < 0)
                    for (int i = 0; i < 4; i++)
                        if (w < 0 && rv[i]) w = i;
                m_owner = w;
                m_held  = 1;
                m_skip  = -1;
            end
        end else if (!rv[m_owner]) begin
            m_owner = -1;
            m_held  = 0;
`ifdef ARB_HOLD_LIMIT_EN
        end else if (m_held == MAX_HOLD) begin
            m_skip  = m_owner;
            m_owner = -1;
            m_held  = 0;
            m_to    = 1'b1;
`endif
        end else begin
            m_held++;
        end
    endtask

    task automatic cycle(input logic [0:3] rv, input logic rs);
        logic [0:3] eg;
        r     = rv;
        reset = rs;
        @(posedge clk);
        model_edge(rv, rs);
        #1;
        eg = 4'b0000;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check("g",       32'(g),       32'(eg));
        check("owner",   32'(owner),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check("busy",    32'(busy),    32'(m_owner >= 0));
        check("timeout", 32'(timeout), 32'(m_to));
    endtask

    initial begin
        logic [0:3] rv;
        r     = 4'b0000;
        reset = 1'b1;
        #2;
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);

        // single request held 3 cycles, then released
        repeat (3) cycle(4'b0010, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);

        // priority, then no preemption, then handover with a dead cycle
        cycle(4'b0111, 1'b0);
        cycle(4'b1111, 1'b0);
        cycle(4'b1011, 1'b0);
        cycle(4'b1011, 1'b0);
        cycle(4'b1011, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);

        // reset in the middle of a grant; request held through it
        cycle(4'b1000, 1'b0);
        cycle(4'b1000, 1'b0);
        cycle(4'b1000, 1'b1);
        cycle(4'b1000, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);

        // two contenders held through several hold windows
        repeat (24) cycle(4'b1100, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);

        // lone requester held
        repeat (16) cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);

        // reset while a forced release would happen
        repeat (MAX_HOLD) cycle(4'b0100, 1'b0);
        cycle(4'b0100, 1'b1);
        cycle(4'b0000, 1'b0);

        // random: requests mostly persist, occasional reset
        rv = 4'b0000;
        repeat (2000) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0) rv[i] = ~rv[i];
            cycle(rv, $urandom_range(0, 99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
